// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite slave register file with independent write/read FSMs.
// Optional byte-lane write strobes: define AXIL_SLV_WSTRB_EN.
module axi_lite_slave_regs #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                       aclk,
  input  logic                       areset_n,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int ADDR_LSB  = $clog2(STRB_W);
  localparam int IDX_W     = ADDR_W - ADDR_LSB;
  localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic                r_ready_en;
  logic                r_aw_held;
  logic                r_w_held;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_bresp;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic                w_awready;
  logic                w_wready;
  logic                w_bvalid;
  logic                w_commit;
  logic                w_arready;
  logic                w_rvalid;
  logic                w_ar_hs;
  logic [ADDR_W-1:0]   w_cm_addr;
  logic [DATA_W-1:0]   w_cm_data;
  logic [IDX_W-1:0]    w_widx;
  logic [IDX_W-1:0]    w_ridx;
  logic                w_wr_ok;
  logic                w_rd_ok;

  // Readies stay low through reset and rise on the first edge after release.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  // Commit fires on the edge where the later of AW/W completes, using live or held payloads.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = r_ready_en && !r_aw_held;
        w_wready  = r_ready_en && !r_w_held;
        if ((r_aw_held || (awvalid && w_awready)) && (r_w_held || (wvalid && w_wready))) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (bready) begin
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    w_ar_hs      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = r_ready_en;
        if (arvalid && w_arready) begin
          w_ar_hs      = 1'b1;
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (rready) begin
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_cm_addr = r_aw_held ? r_awaddr : awaddr;
  assign w_cm_data = r_w_held  ? r_wdata  : wdata;
  assign w_widx    = w_cm_addr[ADDR_W-1:ADDR_LSB];
  assign w_ridx    = araddr[ADDR_W-1:ADDR_LSB];
  assign w_wr_ok   = (w_widx < IDX_W'(NUM_REGS));
  assign w_rd_ok   = (w_ridx < IDX_W'(NUM_REGS));

`ifdef AXIL_SLV_WSTRB_EN
  logic [STRB_W-1:0] r_wstrb;
  logic [STRB_W-1:0] w_cm_strb;
  logic              w_unused_bits;

  assign w_cm_strb     = r_w_held ? r_wstrb : wstrb;
  assign w_unused_bits = &{1'b0, w_cm_addr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_wstrb <= '0;
    end else if (!w_commit && wvalid && w_wready) begin
      r_wstrb <= wstrb;
    end
  end
`else
  logic w_unused_bits;

  // The upstream master drives wstrb as zero, so lanes are not honoured in this build.
  assign w_unused_bits = &{1'b0, wstrb, w_cm_addr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};
`endif

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_bresp   <= RESP_OKAY;
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= '0;
      end
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (w_wr_ok) begin
`ifdef AXIL_SLV_WSTRB_EN
        for (int b = 0; b < STRB_W; b++) begin
          if (w_cm_strb[b]) begin
            r_regs[w_widx[REG_IDX_W-1:0]][b*8 +: 8] <= w_cm_data[b*8 +: 8];
          end
        end
`else
        r_regs[w_widx[REG_IDX_W-1:0]] <= w_cm_data;
`endif
      end
    end else begin
      if (awvalid && w_awready) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= awaddr;
      end
      if (wvalid && w_wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata;
      end
    end
  end

  // Read samples the pre-commit register value when it shares an edge with a write.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_ok ? r_regs[w_ridx[REG_IDX_W-1:0]] : '0;
      r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign regs_o[k*DATA_W +: DATA_W] = r_regs[k];
    end
  endgenerate

  assign awready = w_awready;
  assign wready  = w_wready;
  assign bvalid  = w_bvalid;
  assign bresp   = r_bresp;
  assign arready = w_arready;
  assign rvalid  = w_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb/tb_axi_lite_slave_regs.sv - randomized self-checking bench for axi_lite_slave_regs.
module tb_axi_lite_slave_regs;

  localparam int NR = 16;

  logic           aclk = 1'b0;
  logic           areset_n = 1'b0;
  logic [11:0]    awaddr = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [31:0]    wdata = '0;
  logic [3:0]     wstrb = '0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b0;
  logic [11:0]    araddr = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [31:0]    rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready = 1'b0;
  logic [NR*32-1:0] regs_o;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] model [NR];

  always #5 aclk = ~aclk;

  axi_lite_slave_regs dut (
    .aclk(aclk), .areset_n(areset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o)
  );

  function automatic logic [1:0] model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[11:2]);
    if (idx >= NR) return 2'b10;
`ifdef AXIL_SLV_WSTRB_EN
    for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
`else
    model[idx] = d;
    if (s === 4'bxxxx) model[idx] = d;
`endif
    return 2'b00;
  endfunction

  function automatic logic [1:0] model_read(input logic [11:0] a, output logic [31:0] d);
    int idx;
    idx = int'(a[11:2]);
    if (idx >= NR) begin
      d = '0;
      return 2'b10;
    end
    d = model[idx];
    return 2'b00;
  endfunction

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int k = 0; k < NR; k++) f[k*32 +: 32] = model[k];
    return f;
  endfunction

  // Drives AW and W with independent start delays; leaves B pending with bready low.
  task automatic wr_req(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int aw_dly, input int w_dly, output logic [1:0] exp_resp,
                        output int b_wait, output bit ready_ok, output bit early_b);
    int c;
    bit aw_done, w_done, aw_hs, w_hs;
    c = 0; aw_done = 0; w_done = 0; ready_ok = 1; early_b = 0; b_wait = -1;
    exp_resp = 2'b11;
    while (!(aw_done && w_done) && c < 40) begin
      awaddr = a; wdata = d; wstrb = s;
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      #1;
      if (aw_done && awready) ready_ok = 0;
      if (w_done && wready) ready_ok = 0;
      if (bvalid) early_b = 1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge aclk); #1;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      c++;
    end
    awvalid = 0; wvalid = 0;
    if (aw_done && w_done) begin
      exp_resp = model_write(a, d, s);
      for (int k = 0; k < 10; k++) begin
        if (bvalid) begin
          b_wait = k;
          break;
        end
        @(posedge aclk); #1;
      end
    end
  endtask

  task automatic b_accept(output logic [1:0] resp, output bit done_ok);
    resp = bresp;
    bready = 1;
    @(posedge aclk); #1;
    done_ok = !bvalid;
    bready = 0;
  endtask

  task automatic rd_req(input logic [11:0] a, output int r_wait);
    int c;
    bit hs;
    c = 0; hs = 0; r_wait = -1;
    araddr = a; arvalid = 1;
    while (!hs && c < 20) begin
      #1;
      hs = arready;
      @(posedge aclk); #1;
      c++;
    end
    arvalid = 0;
    if (hs) begin
      for (int k = 0; k < 10; k++) begin
        if (rvalid) begin
          r_wait = k;
          break;
        end
        @(posedge aclk); #1;
      end
    end
  endtask

  task automatic r_accept(output logic [31:0] d, output logic [1:0] resp, output bit done_ok);
    d = rdata; resp = rresp;
    rready = 1;
    @(posedge aclk); #1;
    done_ok = !rvalid;
    rready = 0;
  endtask

  task automatic test_reset();
    #1;
    n_total++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) $display("FAIL reset_ctl got=%b exp=00000", {awready, wready, arready, bvalid, rvalid}); else n_pass++;
    n_total++; if ({bresp, rresp, rdata} !== 36'h0) $display("FAIL reset_payload got=%h exp=0", {bresp, rresp, rdata}); else n_pass++;
    n_total++; if (regs_o !== '0) $display("FAIL reset_regs got=%h exp=0", regs_o); else n_pass++;
    repeat (2) @(posedge aclk);
    #1; areset_n = 1; #1;
    n_total++; if ({awready, wready, arready} !== 3'b000) $display("FAIL ready_before_edge got=%b exp=000", {awready, wready, arready}); else n_pass++;
    @(posedge aclk); #1;
    n_total++; if ({awready, wready, arready} !== 3'b111) $display("FAIL ready_after_edge got=%b exp=111", {awready, wready, arready}); else n_pass++;
  endtask

  task automatic test_same_cycle();
    logic [1:0] er, r; int bw; bit rok, eb, ok;
    wr_req(12'h008, 32'hDEADBEEF, 4'hF, 0, 0, er, bw, rok, eb);
    n_total++; if (bw !== 0) $display("FAIL same_cycle_b_latency got=%0d exp=0", bw); else n_pass++;
    b_accept(r, ok);
    n_total++; if (r !== 2'b00) $display("FAIL same_cycle_bresp got=%b exp=00", r); else n_pass++;
    n_total++; if (!ok) $display("FAIL same_cycle_b_release got=1 exp=0"); else n_pass++;
    n_total++; if (regs_o[2*32 +: 32] !== 32'hDEADBEEF) $display("FAIL same_cycle_reg2 got=%h exp=deadbeef", regs_o[2*32 +: 32]); else n_pass++;
  endtask

  task automatic test_w_before_aw();
    logic [1:0] er, r; logic [31:0] d, ed; int bw, rw; bit rok, eb, ok;
    wr_req(12'h004, 32'h12345678, 4'hF, 3, 0, er, bw, rok, eb);
    n_total++; if (!rok) $display("FAIL w_first_wready_low got=1 exp=0"); else n_pass++;
    n_total++; if (eb) $display("FAIL w_first_early_b got=1 exp=0"); else n_pass++;
    n_total++; if (bw !== 0) $display("FAIL w_first_b_latency got=%0d exp=0", bw); else n_pass++;
    b_accept(r, ok);
    n_total++; if (regs_o[32 +: 32] !== 32'h12345678) $display("FAIL w_first_reg1 got=%h exp=12345678", regs_o[32 +: 32]); else n_pass++;
    rd_req(12'h004, rw);
    n_total++; if (rw !== 0) $display("FAIL read_latency got=%0d exp=0", rw); else n_pass++;
    void'(model_read(12'h004, ed));
    r_accept(d, r, ok);
    n_total++; if ({r, d} !== {2'b00, ed}) $display("FAIL read_reg1 got=%h exp=%h", {r, d}, {2'b00, ed}); else n_pass++;
    n_total++; if (!ok) $display("FAIL read_release got=1 exp=0"); else n_pass++;
  endtask

  task automatic test_decode_err();
    logic [1:0] er, r; logic [31:0] d; int bw, rw; bit rok, eb, ok;
    rd_req(12'h0C0, rw);
    r_accept(d, r, ok);
    n_total++; if ({r, d} !== {2'b10, 32'h0}) $display("FAIL oor_read got=%h exp=%h", {r, d}, {2'b10, 32'h0}); else n_pass++;
    wr_req(12'h0C0, 32'hCAFEF00D, 4'hF, 1, 0, er, bw, rok, eb);
    b_accept(r, ok);
    n_total++; if (r !== 2'b10) $display("FAIL oor_bresp got=%b exp=10", r); else n_pass++;
    n_total++; if (regs_o !== model_flat()) $display("FAIL oor_regs_unchanged got=%h exp=%h", regs_o, model_flat()); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [1:0] er, r; logic [31:0] d, ed; int bw, rw; bit rok, eb, ok, stable;
    wr_req(12'h010, 32'h0BADC0DE, 4'hF, 0, 0, er, bw, rok, eb);
    stable = 1;
    awaddr = 12'h014; wdata = 32'h55555555; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (!bvalid || bresp !== 2'b00 || awready || wready) stable = 0;
      @(posedge aclk); #1;
    end
    awvalid = 0; wvalid = 0;
    n_total++; if (!stable) $display("FAIL b_hold_stable got=0 exp=1"); else n_pass++;
    b_accept(r, ok);
    n_total++; if (r !== er) $display("FAIL b_hold_resp got=%b exp=%b", r, er); else n_pass++;
    n_total++; if (regs_o !== model_flat()) $display("FAIL b_hold_no_second_write got=%h exp=%h", regs_o, model_flat()); else n_pass++;
    rd_req(12'h010, rw);
    void'(model_read(12'h010, ed));
    stable = 1;
    for (int k = 0; k < 5; k++) begin
      if (!rvalid || rdata !== ed || rresp !== 2'b00) stable = 0;
      @(posedge aclk); #1;
    end
    n_total++; if (!stable) $display("FAIL r_hold_stable got=0 exp=1"); else n_pass++;
    r_accept(d, r, ok);
    n_total++; if (d !== ed) $display("FAIL r_hold_data got=%h exp=%h", d, ed); else n_pass++;
  endtask

  task automatic test_strobe();
    logic [1:0] er, r; int bw; bit rok, eb, ok;
    logic [31:0] exp0;
`ifdef AXIL_SLV_WSTRB_EN
    exp0 = 32'h11BB33DD;
`else
    exp0 = 32'hAABBCCDD;
`endif
    wr_req(12'h000, 32'h11223344, 4'hF, 0, 0, er, bw, rok, eb);
    b_accept(r, ok);
    wr_req(12'h000, 32'hAABBCCDD, 4'b0101, 0, 2, er, bw, rok, eb);
    b_accept(r, ok);
    n_total++; if (regs_o[31:0] !== exp0) $display("FAIL strobe_reg0 got=%h exp=%h", regs_o[31:0], exp0); else n_pass++;
    wr_req(12'h000, 32'h99999999, 4'b0000, 0, 0, er, bw, rok, eb);
    b_accept(r, ok);
    n_total++; if (r !== 2'b00) $display("FAIL strobe_zero_bresp got=%b exp=00", r); else n_pass++;
    n_total++; if (regs_o !== model_flat()) $display("FAIL strobe_zero_regs got=%h exp=%h", regs_o, model_flat()); else n_pass++;
  endtask

  task automatic test_concurrent();
    logic [31:0] old_v;
    awaddr = 12'h00C; wdata = 32'hFEEDFACE; wstrb = 4'hF; araddr = 12'h00C;
    awvalid = 1; wvalid = 1; arvalid = 1;
    void'(model_read(12'h00C, old_v));
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    n_total++; if ({bvalid, rvalid} !== 2'b11) $display("FAIL concurrent_valids got=%b exp=11", {bvalid, rvalid}); else n_pass++;
    n_total++; if (rdata !== old_v) $display("FAIL concurrent_old_value got=%h exp=%h", rdata, old_v); else n_pass++;
    void'(model_write(12'h00C, 32'hFEEDFACE, 4'hF));
    bready = 1; rready = 1;
    @(posedge aclk); #1;
    bready = 0; rready = 0;
    n_total++; if ({bvalid, rvalid} !== 2'b00) $display("FAIL concurrent_release got=%b exp=00", {bvalid, rvalid}); else n_pass++;
    n_total++; if (regs_o !== model_flat()) $display("FAIL concurrent_regs got=%h exp=%h", regs_o, model_flat()); else n_pass++;
  endtask

  task automatic test_random();
    logic [11:0] a; logic [31:0] d, ed; logic [3:0] s; logic [1:0] er, r; int bw, rw, errs; bit rok, eb, ok;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      a = 12'(($urandom_range(0, 31) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        wr_req(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), er, bw, rok, eb);
        b_accept(r, ok);
        n_total++; if ({bw, r} !== {32'd0, er}) $display("FAIL rand_write i=%0d got=%0d/%b exp=0/%b", i, bw, r, er); else n_pass++;
        n_total++; if (regs_o !== model_flat()) $display("FAIL rand_regs i=%0d got=%h exp=%h", i, regs_o, model_flat()); else n_pass++;
      end else begin
        er = model_read(a, ed);
        rd_req(a, rw);
        r_accept(d, r, ok);
        n_total++; if ({rw, r, d} !== {32'd0, er, ed}) $display("FAIL rand_read i=%0d got=%h exp=%h", i, {rw, r, d}, {32'd0, er, ed}); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] er, r; int bw; bit rok, eb, ok;
    awaddr = 12'h014; awvalid = 1;
    @(posedge aclk); #1;
    awvalid = 0;
    areset_n = 0; #1;
    for (int k = 0; k < NR; k++) model[k] = '0;
    n_total++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b0) $display("FAIL mid_reset_ctl got=%b exp=00000", {bvalid, rvalid, awready, wready, arready}); else n_pass++;
    n_total++; if (regs_o !== '0) $display("FAIL mid_reset_regs got=%h exp=0", regs_o); else n_pass++;
    @(posedge aclk); #1;
    areset_n = 1;
    @(posedge aclk); #1;
    wr_req(12'h018, 32'h600DF00D, 4'hF, 3, 0, er, bw, rok, eb);
    n_total++; if (eb) $display("FAIL mid_reset_stale_aw got=1 exp=0"); else n_pass++;
    b_accept(r, ok);
    n_total++; if ({bw, r} !== {32'd0, 2'b00}) $display("FAIL mid_reset_write got=%0d/%b exp=0/00", bw, r); else n_pass++;
    n_total++; if (regs_o !== model_flat()) $display("FAIL mid_reset_regs_after got=%h exp=%h", regs_o, model_flat()); else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < NR; k++) model[k] = '0;
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_decode_err();
    test_backpressure();
    test_strobe();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite slave endpoint that terminates the master's AW/W/B and AR/R channels into a memory-mapped register file. It sits directly downstream of the AXI4-Lite master on the same link. Write and read paths are independent FSMs. Register contents are also exported as a flat bus for observation and use by downstream logic.

Parameters:
ADDR_W, 12, address width (matches addr_t)
DATA_W, 32, data width; must be 32 or 64; STRB_W = DATA_W/8
NUM_REGS, 16, number of DATA_W-wide registers; word index = addr[ADDR_W-1:$clog2(STRB_W)]

Ports:
aclk  in  1  clock
areset_n  in  1  asynchronous active-low reset
awaddr  in  ADDR_W  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_W  write data
wstrb  in  STRB_W  byte-lane strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_W  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_W  read data
rresp  out  2  read response: OKAY or SLVERR
rvalid  out  1  read data valid
rready  in  1  read data ready
regs_o  out  NUM_REGS*DATA_W  register file contents; reg k at bits [k*DATA_W +: DATA_W]

Behaviour:
- Reset: async assert clears all registers, holding flops and FSMs. While areset_n=0: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; regs_o = 0. Ready outputs rise on the first clock edge after deassertion.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: awready=1 until an AW handshake is captured (aw_held). wready=1 until a W handshake is captured (w_held). AW and W are accepted in either order or in the same cycle. Each channel is accepted exactly once per transaction.
  - When aw_held && w_held at an edge: commit the write, clear both held flags, set bvalid=1 with bresp, and go to W_RESP. Result: bvalid is visible one cycle after the cycle in which the later of the AW/W handshakes completed.
  - W_RESP: awready=wready=0. bvalid and bresp stay stable until bvalid && bready, then return to W_IDLE. bready may already be high when bvalid rises (single-cycle response).
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On arvalid && arready: register rdata/rresp from the current register contents and go to R_DATA.
  - R_DATA: arready=0, rvalid=1. rdata and rresp are held until rvalid && rready, then return to R_IDLE. One-cycle address-to-data latency.
- Decode: index < NUM_REGS gives OKAY. Otherwise SLVERR: the write is dropped and the read returns rdata=0. Address low bits below word granularity are ignored.
- Simultaneous read and write to the same register: a read whose AR handshake shares an edge with the write commit returns the old value.
- Write and read FSMs run concurrently with no mutual blocking.
- A mid-transaction reset discards held AW/W and any pending B/R response. No response is issued after reset.
- Valid outputs never drop before their handshake. Payloads never change while valid is high.

Optional Feature:
Macro AXIL_SLV_WSTRB_EN.
- Defined: only byte lanes with wstrb[i]=1 are updated. wstrb=0 leaves the register unchanged but still returns OKAY.
- Undefined: wstrb is ignored and the full word is written. This default is required because the existing master drives wstrb=4'b0000.

Test Plan:
- Write 0xDEADBEEF to addr 0x008 with AW and W in the same cycle, bready=1 -> bvalid one cycle later, bresp=00, regs_o reg2=0xDEADBEEF.
- W at cycle 0 and AW at cycle 3, addr 0x004, data 0x12345678 -> wready low from cycle 1, bvalid at cycle 4, reg1 updated; then read 0x004 -> rvalid the cycle after the AR handshake, rdata=0x12345678, rresp=00.
- Read 0x0C0 (index 48 ≥ 16) -> rresp=10, rdata=0. Write 0x0C0 -> bresp=10 and regs_o unchanged.
- Hold bready=0 for 5 cycles after bvalid -> bvalid and bresp stable, awready=wready=0, no second write accepted. Hold rready=0 -> rdata stable.
- With AXIL_SLV_WSTRB_EN, reg0=0x11223344, write 0xAABBCCDD with wstrb=4'b0101 -> reg0=0x11BB33DD. Without the macro -> 0xAABBCCDD.
- Assert areset_n=0 mid-write after the AW handshake only, then release -> all valids 0, regs_o=0, and the next full write completes normally.
